// File: rtl/udp_tx_pkg.sv
// Shared types, constants and CRC/checksum helpers for the UDP transmit framer.
// Pure declarations: no latency, no flow control.
package udp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CSUM,
        REQ,
        HDR,
        PAY,
        PAD,
        FCS
    } txState_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam int          HDR_LEN       = 42;
    localparam int          MIN_BODY      = 60;
    localparam int          MAX_PAY       = 1472;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

    typedef struct packed {
        logic [47:0] remoteMac;
        logic [47:0] innerMac;
        logic [31:0] localIp;
        logic [31:0] remoteIp;
        logic [15:0] localPort;
        logic [15:0] remotePort;
        logic [10:0] payLen;
    } txCmd_t;

    // Reflected CRC-32 (poly 04C11DB7 bit-reversed), one byte, LSB first.
    function automatic logic [31:0] crc32Byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Two end-around-carry folds leave at most 16 bits, then one's complement.
    function automatic logic [15:0] ipFold(input logic [31:0] s);
        logic [16:0] f1;
        logic [15:0] f2;
        f1 = {1'b0, s[15:0]} + {1'b0, s[31:16]};
        f2 = f1[15:0] + {15'h0, f1[16]};
        return ~f2;
    endfunction

endpackage

// File: rtl/udp_tx_framer_crc32_d8.sv
// Byte-serial reflected CRC-32 register for the Ethernet FCS.
// Latency: Crc reflects every byte presented with Ena on the previous edge.
// Backpressure: none; caller gates Ena.
module crc32_d8
    import udp_tx_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Init,
    input  logic        Ena,
    input  logic [7:0]  Data,
    output logic [31:0] Crc
);

    logic [31:0] crcNxt;

    always_comb begin
        crcNxt = Crc;
        if (Init) begin
            crcNxt = CRC_INIT;
        end else if (Ena) begin
            crcNxt = crc32Byte(Crc, Data);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Crc <= CRC_INIT;
        end else begin
            Crc <= crcNxt;
        end
    end

endmodule

// File: rtl/udp_tx_framer.sv
// UDP/IPv4/Ethernet transmit framer; UDP_TX_FCS_EN appends the CRC-32 FCS.
// Latency: Start to ReqOut 7 cycles, grant to SoFOut 1 cycle, then 1 byte/cycle.
// Backpressure: only payload may stall (PayRdy/PayVal); header, pad and FCS never bubble.
module udp_tx_framer
    import udp_tx_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [47:0] InnerMAC,
    input  logic [31:0] IPD,
    input  logic [15:0] PortD,
    input  logic [47:0] RemoteMAC,
    input  logic [31:0] RemoteIP,
    input  logic [15:0] RemotePort,
    input  logic        Start,
    input  logic [10:0] PayLen,
    output logic        Busy,
    output logic        LenErr,
    output logic        PayRdy,
    input  logic        PayVal,
    input  logic [7:0]  PayData,
    output logic        ReqOut,
    input  logic        ReqConfirm,
    output logic        SoFOut,
    output logic        EoFOut,
    output logic        ValOut,
    output logic [7:0]  DataOut
);

    localparam logic [10:0] PAD_PAY  = 11'(MIN_BODY - HDR_LEN);
    localparam logic [10:0] HDR_LAST = 11'(HDR_LEN - 1);

`ifdef UDP_TX_FCS_EN
    localparam txState_t TAIL = FCS;
`else
    localparam txState_t TAIL = IDLE;
`endif

    txState_t     state, stateNxt;
    logic [10:0]  cnt, cntNxt;
    txCmd_t       cmd;
    logic [31:0]  acc;
    logic [15:0]  ipCsum, ipId;
    logic         lenOk, startOk, startAcc, payTake, padNeeded;
    logic [10:0]  padLen;
    logic [15:0]  totLen, udpLen, wordA, wordB;
    logic [335:0] hdrVec;
    logic [5:0]   hIdx;
    logic [8:0]   bitOff;
    logic [7:0]   hdrByte;
    logic         valNxt, sofNxt, eofNxt;
    logic [7:0]   dataNxt;

    // EoFOut keeps Busy high for one extra cycle so a Start coinciding with it is dropped.
    assign Busy      = (state != IDLE) || EoFOut;
    assign ReqOut    = (state == REQ);
    assign PayRdy    = (state == PAY) && (cnt != 11'd0);
    assign lenOk     = (PayLen != 11'd0) && (PayLen <= 11'(MAX_PAY));
    assign startOk   = Start && !Busy;
    assign startAcc  = startOk && lenOk;
    assign payTake   = PayRdy && PayVal;
    assign padNeeded = cmd.payLen < PAD_PAY;
    assign padLen    = PAD_PAY - cmd.payLen;
    assign totLen    = 16'd28 + {5'd0, cmd.payLen};
    assign udpLen    = 16'd8 + {5'd0, cmd.payLen};

    assign hdrVec = {cmd.remoteMac, cmd.innerMac, ETH_TYPE_IPV4,
                     8'h45, 8'h00, totLen, ipId, 8'h40, 8'h00, 8'h40, IP_PROTO_UDP,
                     ipCsum, cmd.localIp, cmd.remoteIp,
                     cmd.localPort, cmd.remotePort, udpLen, 16'h0000};
    assign hIdx    = (state == HDR) ? cnt[5:0] : 6'd0;
    assign bitOff  = 9'd328 - {hIdx, 3'b000};
    assign hdrByte = hdrVec[bitOff +: 8];

`ifdef UDP_TX_FCS_EN
    logic [31:0] crc, fcsWord;
    logic [7:0]  fcsByte;

    crc32_d8 uCrc (
        .Clk  (Clk),
        .Rst  (Rst),
        .Init (startAcc),
        .Ena  (valNxt && (state != FCS)),
        .Data (dataNxt),
        .Crc  (crc)
    );

    assign fcsWord = ~crc;
    assign fcsByte = fcsWord[{cnt[1:0], 3'b000} +: 8];
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
        end
    end

    // cnt is a step index in CSUM/HDR/FCS and a down-counter of remaining bytes in PAY/PAD.
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        case (state)
            IDLE: begin
                cntNxt = '0;
                if (startAcc) stateNxt = CSUM;
            end
            CSUM: begin
                if (cnt == 11'd5) begin
                    stateNxt = REQ;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + 11'd1;
                end
            end
            REQ: begin
                if (ReqConfirm) begin
                    stateNxt = HDR;
                    cntNxt   = 11'd1;
                end
            end
            HDR: begin
                if (cnt == HDR_LAST) begin
                    stateNxt = PAY;
                    cntNxt   = cmd.payLen;
                end else begin
                    cntNxt = cnt + 11'd1;
                end
            end
            PAY: begin
                if (payTake) begin
                    cntNxt = cnt - 11'd1;
                    if (cnt == 11'd1) begin
                        if (padNeeded) begin
                            stateNxt = PAD;
                            cntNxt   = padLen;
                        end else begin
                            stateNxt = TAIL;
                        end
                    end
                end
            end
            PAD: begin
                cntNxt = cnt - 11'd1;
                if (cnt == 11'd1) stateNxt = TAIL;
            end
`ifdef UDP_TX_FCS_EN
            FCS: begin
                cntNxt = cnt + 11'd1;
                if (cnt == 11'd3) begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                end
            end
`endif
            default: begin
                stateNxt = IDLE;
                cntNxt   = '0;
            end
        endcase
    end

    always_comb begin
        valNxt  = 1'b0;
        sofNxt  = 1'b0;
        eofNxt  = 1'b0;
        dataNxt = 8'h00;
        case (state)
            REQ: begin
                valNxt  = ReqConfirm;
                sofNxt  = ReqConfirm;
                dataNxt = ReqConfirm ? hdrByte : 8'h00;
            end
            HDR: begin
                valNxt  = 1'b1;
                dataNxt = hdrByte;
            end
            PAY: begin
                valNxt  = payTake;
                dataNxt = payTake ? PayData : 8'h00;
                eofNxt  = payTake && (cnt == 11'd1) && !padNeeded && (TAIL == IDLE);
            end
            PAD: begin
                valNxt = 1'b1;
                eofNxt = (cnt == 11'd1) && (TAIL == IDLE);
            end
`ifdef UDP_TX_FCS_EN
            FCS: begin
                valNxt  = 1'b1;
                dataNxt = fcsByte;
                eofNxt  = (cnt == 11'd3);
            end
`endif
            default: begin
                valNxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        wordA = 16'h0000;
        wordB = 16'h0000;
        case (cnt[2:0])
            3'd0: begin wordA = {8'h45, 8'h00};         wordB = totLen;                end
            3'd1: begin wordA = ipId;                   wordB = {8'h40, 8'h00};        end
            3'd2: begin wordA = {8'h40, IP_PROTO_UDP};  wordB = cmd.localIp[31:16];    end
            3'd3: begin wordA = cmd.localIp[15:0];      wordB = cmd.remoteIp[31:16];   end
            3'd4: begin wordA = cmd.remoteIp[15:0];     wordB = 16'h0000;              end
            default: begin wordA = 16'h0000;            wordB = 16'h0000;              end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cmd    <= '0;
            acc    <= '0;
            ipCsum <= '0;
            ipId   <= '0;
        end else begin
            if (startAcc) begin
                cmd <= '{remoteMac: RemoteMAC, innerMac: InnerMAC, localIp: IPD,
                         remoteIp: RemoteIP, localPort: PortD, remotePort: RemotePort,
                         payLen: PayLen};
                acc <= '0;
            end
            if (state == CSUM) begin
                if (cnt == 11'd5) begin
                    ipCsum <= ipFold(acc);
                end else begin
                    acc <= acc + {16'h0, wordA} + {16'h0, wordB};
                end
            end
            if (eofNxt) ipId <= ipId + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ValOut  <= 1'b0;
            SoFOut  <= 1'b0;
            EoFOut  <= 1'b0;
            DataOut <= 8'h00;
            LenErr  <= 1'b0;
        end else begin
            ValOut  <= valNxt;
            SoFOut  <= sofNxt;
            EoFOut  <= eofNxt;
            DataOut <= dataNxt;
            LenErr  <= startOk && !lenOk;
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: lengths, checksums, arbitration, bubbles, reset abort.
module tb_udp_tx_framer;

    localparam logic [47:0] RMAC  = 48'h02_11_22_33_44_55;
    localparam logic [47:0] IMAC  = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [31:0] IPD_V = 32'hC0A8_0505;
    localparam logic [31:0] RIP_V = 32'hC0A8_0501;
    localparam logic [15:0] PD_V  = 16'h1234;
    localparam logic [15:0] RP_V  = 16'h5678;
    localparam int          HL    = 42;
`ifdef UDP_TX_FCS_EN
    localparam int          FCSB  = 4;
`else
    localparam int          FCSB  = 0;
`endif

    logic        Clk, Rst, Start, PayVal, ReqConfirm;
    logic [10:0] PayLen;
    logic [7:0]  PayData;
    logic        Busy, LenErr, PayRdy, ReqOut, SoFOut, EoFOut, ValOut;
    logic [7:0]  DataOut;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  payQ[$];
    logic [7:0]  sent[$];
    logic [7:0]  frm[$];
    int          eofIdx, gaps, badGaps, cyc;
    bit          bubbleEn;
    logic        payRdyS;

    udp_tx_framer dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .InnerMAC   (IMAC),
        .IPD        (IPD_V),
        .PortD      (PD_V),
        .RemoteMAC  (RMAC),
        .RemoteIP   (RIP_V),
        .RemotePort (RP_V),
        .Start      (Start),
        .PayLen     (PayLen),
        .Busy       (Busy),
        .LenErr     (LenErr),
        .PayRdy     (PayRdy),
        .PayVal     (PayVal),
        .PayData    (PayData),
        .ReqOut     (ReqOut),
        .ReqConfirm (ReqConfirm),
        .SoFOut     (SoFOut),
        .EoFOut     (EoFOut),
        .ValOut     (ValOut),
        .DataOut    (DataOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Payload source: one byte offered per cycle, optionally withholding every third cycle.
    initial begin
        PayVal  = 1'b0;
        PayData = 8'h00;
        payRdyS = 1'b0;
        cyc     = 0;
        forever begin
            @(negedge Clk);
            if (PayVal && payRdyS && payQ.size() > 0) payQ.delete(0);
            cyc++;
            payRdyS = PayRdy;
            PayVal  = (payQ.size() > 0) && !(bubbleEn && (cyc % 3 == 0));
            PayData = (payQ.size() > 0) ? payQ[0] : 8'h00;
        end
    end

    task automatic startFrame(input int len, input int gDelay);
        int k;
        int badHold;
        logic [31:0] dead;
        logic [7:0] b;
        dead = 32'hDEAD_BEEF;
        payQ.delete();
        sent.delete();
        for (int i = 0; i < len; i++) begin
            b = (len == 4) ? dead[31-8*i -: 8] : 8'(i * 7 + 3);
            payQ.push_back(b);
            sent.push_back(b);
        end
        PayLen = 11'(len);
        Start  = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("busyOnStart", Busy, 1);
        k = 1;
        while (!ReqOut && k < 20) begin
            @(negedge Clk);
            k++;
        end
        chk("startToReq", k, 7);
        badHold = 0;
        for (int i = 0; i < gDelay; i++) begin
            @(negedge Clk);
            if (!ReqOut || ValOut) badHold++;
        end
        if (gDelay > 0) chk("reqHeldNoVal", badHold, 0);
        ReqConfirm = 1'b1;
        @(negedge Clk);
        ReqConfirm = 1'b0;
        chk("sofAfterGrant", {SoFOut, ValOut, ReqOut}, 3'b110);
    endtask

    task automatic captureFrame(input int len);
        frm.delete();
        eofIdx  = -1;
        gaps    = 0;
        badGaps = 0;
        for (int c = 0; c < 4000 && eofIdx < 0; c++) begin
            if (c > 0) @(negedge Clk);
            if (ValOut) begin
                frm.push_back(DataOut);
                if (EoFOut) eofIdx = frm.size() - 1;
            end else begin
                gaps++;
                if (frm.size() < HL || frm.size() >= HL + len) badGaps++;
            end
        end
        chk("eofSeen", eofIdx >= 0, 1);
        chk("busyAtEof", Busy, 1);
    endtask

    task automatic checkFrame(input int len, input logic [15:0] ipid, input logic [15:0] csum);
        logic [7:0]  h[HL];
        logic [15:0] tl, ul;
        logic [31:0] r;
        logic        fb;
        int          body, bad;
        tl   = 16'(28 + len);
        ul   = 16'(8 + len);
        body = (HL + len < 60) ? 60 : HL + len;
        for (int i = 0; i < 6; i++) begin
            h[i]     = RMAC[47-8*i -: 8];
            h[6+i]   = IMAC[47-8*i -: 8];
        end
        h[12] = 8'h08;  h[13] = 8'h00;  h[14] = 8'h45;  h[15] = 8'h00;
        h[16] = tl[15:8]; h[17] = tl[7:0]; h[18] = ipid[15:8]; h[19] = ipid[7:0];
        h[20] = 8'h40;  h[21] = 8'h00;  h[22] = 8'h40;  h[23] = 8'h11;
        h[24] = csum[15:8]; h[25] = csum[7:0];
        for (int i = 0; i < 4; i++) begin
            h[26+i] = IPD_V[31-8*i -: 8];
            h[30+i] = RIP_V[31-8*i -: 8];
        end
        h[34] = PD_V[15:8]; h[35] = PD_V[7:0]; h[36] = RP_V[15:8]; h[37] = RP_V[7:0];
        h[38] = ul[15:8];   h[39] = ul[7:0];   h[40] = 8'h00;      h[41] = 8'h00;

        chk("frameLen", frm.size(), body + FCSB);
        chk("eofPos", eofIdx, body + FCSB - 1);
        if (frm.size() >= body + FCSB) begin
            bad = 0;
            for (int i = 0; i < HL; i++) if (frm[i] !== h[i]) bad++;
            chk("hdrBytes", bad, 0);
            chk("totLenField", {frm[16], frm[17]}, tl);
            chk("ipIdField", {frm[18], frm[19]}, ipid);
            chk("ipCsumField", {frm[24], frm[25]}, csum);
            chk("udpLenField", {frm[38], frm[39]}, ul);
            bad = 0;
            for (int i = 0; i < len; i++) if (frm[HL+i] !== sent[i]) bad++;
            chk("payloadBytes", bad, 0);
            bad = 0;
            for (int i = HL + len; i < body; i++) if (frm[i] !== 8'h00) bad++;
            chk("padBytes", bad, 0);
`ifdef UDP_TX_FCS_EN
            // Non-reflected shift register fed LSB-first; a good frame leaves the magic residue.
            r = 32'hFFFF_FFFF;
            for (int i = 0; i < frm.size(); i++) begin
                for (int j = 0; j < 8; j++) begin
                    fb = r[31] ^ frm[i][j];
                    r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
                end
            end
            chk("fcsResidue", r, 32'hC704_DD7B);
`else
            r  = 32'h0;
            fb = 1'b0;
            chk("eofOnLastBody", eofIdx, body - 1);
`endif
        end else begin
            chk("frameTooShort", frm.size(), body + FCSB);
        end
        chk("bubblesOnlyInPay", badGaps, 0);
    endtask

    initial begin
        int lens[2];
        int badIdle;
        Rst        = 1'b1;
        Start      = 1'b0;
        PayLen     = 11'd0;
        ReqConfirm = 1'b0;
        bubbleEn   = 1'b0;
        repeat (3) @(negedge Clk);
        chk("resetOutputs", {ReqOut, ValOut, SoFOut, EoFOut, Busy, LenErr, PayRdy, DataOut}, 15'h0);
        Rst = 1'b0;
        @(negedge Clk);
        chk("idleOutputs", {ReqOut, ValOut, SoFOut, EoFOut, Busy, LenErr, PayRdy, DataOut}, 15'h0);

        lens[0] = 0;
        lens[1] = 1473;
        for (int t = 0; t < 2; t++) begin
            PayLen = 11'(lens[t]);
            Start  = 1'b1;
            @(negedge Clk);
            Start = 1'b0;
            chk("lenErrPulse", {LenErr, Busy}, 2'b10);
            @(negedge Clk);
            chk("lenErrSingle", {LenErr, Busy, ReqOut}, 3'b000);
            badIdle = 0;
            repeat (10) begin
                @(negedge Clk);
                if (ReqOut || Busy || ValOut) badIdle++;
            end
            chk("lenErrStaysIdle", badIdle, 0);
        end

        // Frame 1: short payload, checksum AF76 with IpId 0000.
        startFrame(4, 0);
        captureFrame(4);
        checkFrame(4, 16'h0000, 16'hAF76);
        @(negedge Clk);
        chk("busyDropsAfterEof", Busy, 0);

        // Frame 2: long grant wait, IpId 0001, Start on the EoFOut cycle must be dropped.
        repeat (2) @(negedge Clk);
        startFrame(4, 100);
        captureFrame(4);
        PayLen = 11'd4;
        Start  = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("startOnEofIgnored", Busy, 0);
        badIdle = 0;
        repeat (10) begin
            @(negedge Clk);
            if (ReqOut || Busy) badIdle++;
        end
        chk("noReqAfterIgnored", badIdle, 0);
        checkFrame(4, 16'h0001, 16'hAF75);

        // Frame 3: maximum payload with upstream bubbles, IpId 0002.
        bubbleEn = 1'b1;
        startFrame(1472, 0);
        captureFrame(1472);
        bubbleEn = 1'b0;
        checkFrame(1472, 16'h0002, 16'hA9B8);
        chk("bubblesSeen", gaps > 0, 1);
        repeat (2) @(negedge Clk);

        // Reset in the middle of the header aborts the frame and clears IpId.
        startFrame(4, 0);
        repeat (10) @(negedge Clk);
        chk("midHdrValid", ValOut, 1);
        Rst = 1'b1;
        @(negedge Clk);
        chk("abortOutputs", {ReqOut, ValOut, SoFOut, EoFOut, Busy, LenErr, PayRdy, DataOut}, 15'h0);
        Rst = 1'b0;
        payQ.delete();
        repeat (2) @(negedge Clk);
        startFrame(4, 0);
        captureFrame(4);
        checkFrame(4, 16'h0000, 16'hAF76);
        repeat (3) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
